// File: rtl/trdb_stream_fifo.sv
// Trace stream output FIFO: buffers aligned 32-bit words with no upstream backpressure.
// It counts dropped words, provides a flush-drain handshake and a level-threshold interrupt.
module trdb_stream_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IRQ_THRESH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              data_i,
    input  logic                     valid_i,
    output logic [31:0]              data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    input  logic                     clear_i,
    output logic                     overflow_o,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [31:0]          r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [PW-1:0]        w_level;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    assign w_pop  = !w_empty && ready_i;
    assign w_push = valid_i && (!w_full || w_pop);
    assign w_drop = valid_i && w_full && !w_pop;

    assign valid_o      = !w_empty;
    assign data_o       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign level_o      = w_level;
    assign irq_o        = (w_level >= PW'(IRQ_THRESH));
    assign overflow_o   = r_overflow;
    assign drop_cnt_o   = r_drop_cnt;
    assign flush_done_o = (r_state == ST_DONE);

    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    // Pushes stay legal in DRAIN: the aligner's residual word arrives after the flush request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (flush_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty && !valid_i) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && w_full && !w_pop));
    a_level_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        level_o <= PW'(DEPTH));
    a_valid_level : assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o == (level_o != '0));

endmodule
